ysyx_25040111_axi_arbiter: RTL and testbench

Two-master to one-slave AXI4 arbiter sitting directly downstream of the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write), driving the single `io_master_*` port out of the core. It grants the bus to one master at a time, forwards that master's channels, steers responses back to it, and releases on completion of the single-beat transaction. Exactly one transaction is outstanding on `io_master_*` at any time.

---
 rtl/ysyx_25040111_axi_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ysyx_25040111_axi_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_axi_arbiter.sv
// ysyx_25040111_axi_arbiter
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter.
// One single-beat transaction is outstanding on io_master_* at any time;
// the owner's channels are wired combinationally once granted, and the bus
// returns to IDLE for at least one cycle between transactions.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   ifu_ar*/ifu_r*           IFU read address / read response
//   lsu_ar*/lsu_r*           LSU read address / read response
//   lsu_aw*/lsu_w*/lsu_b*    LSU write address / write data / write response
//   io_master_*              single AXI4 master port out of the core
//
// Configuration:
//   YSYX_25040111_ARB_RR_EN  defined: round-robin between IFU and LSU using a
//                            1-bit last_owner register (LSU write still beats
//                            LSU read). Undefined: fixed priority
//                            LSU write > LSU read > IFU read.
module ysyx_25040111_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    input  logic                ifu_rready,
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [2:0]          lsu_arsize,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_rready,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [2:0]          lsu_awsize,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,
    output logic                io_master_arvalid,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [3:0]          io_master_arid,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    input  logic                io_master_arready,
    input  logic                io_master_rvalid,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic                io_master_rlast,
    input  logic [3:0]          io_master_rid,
    output logic                io_master_rready,
    output logic                io_master_awvalid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [3:0]          io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    input  logic                io_master_awready,
    output logic                io_master_wvalid,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    input  logic                io_master_wready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    input  logic [3:0]          io_master_bid,
    output logic                io_master_bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} st_t;

    st_t st, st_nxt, grant;

    // Response IDs are not inspected: only one transaction is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{io_master_rid, io_master_bid};

    // Payload fields are qualified by the valids below, so they pass straight through.
    assign io_master_arlen   = '0;
    assign io_master_arburst = 2'b01;
    assign io_master_awid    = 4'd1;
    assign io_master_awlen   = '0;
    assign io_master_awburst = 2'b01;
    assign io_master_awaddr  = lsu_awaddr;
    assign io_master_awsize  = lsu_awsize;
    assign io_master_wdata   = lsu_wdata;
    assign io_master_wstrb   = lsu_wstrb;
    assign io_master_wlast   = lsu_wlast;
    assign ifu_rdata         = io_master_rdata;
    assign ifu_rresp         = io_master_rresp;
    assign lsu_rdata         = io_master_rdata;
    assign lsu_rresp         = io_master_rresp;
    assign lsu_bresp         = io_master_bresp;

`ifdef YSYX_25040111_ARB_RR_EN
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;
    owner_t last_owner;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_owner <= OWN_IFU;
        else if (st == IDLE && st_nxt != IDLE)
            last_owner <= (st_nxt == IFU_RD) ? OWN_IFU : OWN_LSU;
    end

    // IFU only wins a conflict when the LSU owned the previous transaction.
    always_comb begin
        grant = IDLE;
        if ((lsu_awvalid || lsu_arvalid) && !(ifu_arvalid && last_owner == OWN_LSU))
            grant = lsu_awvalid ? LSU_WR : LSU_RD;
        else if (ifu_arvalid)
            grant = IFU_RD;
    end
`else
    always_comb begin
        grant = IDLE;
        if (lsu_awvalid)
            grant = LSU_WR;
        else if (lsu_arvalid)
            grant = LSU_RD;
        else if (ifu_arvalid)
            grant = IFU_RD;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    always_comb begin
        st_nxt            = st;
        io_master_arvalid = 1'b0;
        io_master_araddr  = ifu_araddr;
        io_master_arid    = '0;
        io_master_arsize  = 3'b010;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        ifu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        lsu_arready       = 1'b0;
        lsu_rvalid        = 1'b0;
        lsu_awready       = 1'b0;
        lsu_wready        = 1'b0;
        lsu_bvalid        = 1'b0;
        case (st)
            IDLE: st_nxt = grant;
            IFU_RD: begin
                io_master_arvalid = ifu_arvalid;
                ifu_arready       = io_master_arready;
                ifu_rvalid        = io_master_rvalid;
                io_master_rready  = ifu_rready;
                if (io_master_rvalid && ifu_rready && io_master_rlast)
                    st_nxt = IDLE;
            end
            LSU_RD: begin
                io_master_arvalid = lsu_arvalid;
                io_master_araddr  = lsu_araddr;
                io_master_arid    = 4'd1;
                io_master_arsize  = lsu_arsize;
                lsu_arready       = io_master_arready;
                lsu_rvalid        = io_master_rvalid;
                io_master_rready  = lsu_rready;
                if (io_master_rvalid && lsu_rready && io_master_rlast)
                    st_nxt = IDLE;
            end
            LSU_WR: begin
                io_master_awvalid = lsu_awvalid;
                lsu_awready       = io_master_awready;
                io_master_wvalid  = lsu_wvalid;
                lsu_wready        = io_master_wready;
                lsu_bvalid        = io_master_bvalid;
                io_master_bready  = lsu_bready;
                if (io_master_bvalid && lsu_bready)
                    st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
module tb_ysyx_25040111_axi_arbiter;

`ifdef YSYX_25040111_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Bit positions of the handshake-signal snapshot compared in the vector table.
    localparam logic [12:0] MARV = 13'h1000, ARID = 13'h0800, RRDY = 13'h0400,
                            MAWV = 13'h0200, MWV  = 13'h0100, BRDY = 13'h0080,
                            IARR = 13'h0040, IRV  = 13'h0020, LARR = 13'h0010,
                            LRV  = 13'h0008, LAWR = 13'h0004, LWR  = 13'h0002,
                            LBV  = 13'h0001;

    logic clk = 1'b0;
    logic rst_n;
    logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [1:0] ifu_rresp;
    logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [2:0] lsu_arsize, lsu_awsize;
    logic [1:0] lsu_rresp, lsu_bresp;
    logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
    logic lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0] lsu_wstrb;
    logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [3:0] m_arid, m_rid, m_awid, m_wstrb, m_bid;
    logic [7:0] m_arlen, m_awlen;
    logic [2:0] m_arsize, m_awsize;
    logic [1:0] m_arburst, m_rresp, m_awburst, m_bresp;
    logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25040111_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize),
        .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .io_master_arvalid(m_arvalid), .io_master_araddr(m_araddr), .io_master_arid(m_arid),
        .io_master_arlen(m_arlen), .io_master_arsize(m_arsize), .io_master_arburst(m_arburst),
        .io_master_arready(m_arready),
        .io_master_rvalid(m_rvalid), .io_master_rdata(m_rdata), .io_master_rresp(m_rresp),
        .io_master_rlast(m_rlast), .io_master_rid(m_rid), .io_master_rready(m_rready),
        .io_master_awvalid(m_awvalid), .io_master_awaddr(m_awaddr), .io_master_awid(m_awid),
        .io_master_awlen(m_awlen), .io_master_awsize(m_awsize), .io_master_awburst(m_awburst),
        .io_master_awready(m_awready),
        .io_master_wvalid(m_wvalid), .io_master_wdata(m_wdata), .io_master_wstrb(m_wstrb),
        .io_master_wlast(m_wlast), .io_master_wready(m_wready),
        .io_master_bvalid(m_bvalid), .io_master_bresp(m_bresp), .io_master_bid(m_bid),
        .io_master_bready(m_bready)
    );

    typedef struct {
        logic rst_n, ifu, lar, law, lw, arr, rv, rl, awr, wr, bv;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, i, la, lw_a, lw_d, arr, rv, rl, awr, wr, bv,
                              input logic [12:0] e);
        vec_t t;
        t = '{r, i, la, lw_a, lw_d, arr, rv, rl, awr, wr, bv, e};
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        ifu_arvalid = 0; ifu_araddr = 32'h8000_1000; ifu_rready = 1;
        lsu_arvalid = 0; lsu_araddr = 32'h0000_2000; lsu_arsize = 3'b010; lsu_rready = 1;
        lsu_awvalid = 0; lsu_awaddr = 32'h0000_3000; lsu_awsize = 3'b010;
        lsu_wvalid = 0; lsu_wdata = 32'h0; lsu_wstrb = 4'hf; lsu_wlast = 1; lsu_bready = 1;
        m_arready = 0; m_rvalid = 0; m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 0; m_rid = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00; m_bid = 0;
    endtask

    // Leaves the bench just after a falling edge, in IDLE with reset released.
    task automatic do_reset();
        @(negedge clk); clr(); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    initial begin
        // rst, ifu, lar, law, lw, arready, rvalid, rlast, awready, wready, bvalid, expected
        v(0,1,1,1,1,1,1,1,1,1,1, '0);
        v(0,1,1,1,1,1,1,1,1,1,1, '0);
        v(1,0,0,1,1,0,0,0,0,0,0, '0);
        v(1,0,0,1,1,0,0,0,0,0,0, MAWV|MWV|BRDY);
        v(1,0,0,1,1,0,0,0,0,1,0, MAWV|MWV|BRDY|LWR);
        v(1,0,0,1,0,0,0,0,1,0,0, MAWV|BRDY|LAWR);
        v(1,0,0,0,0,0,0,0,0,0,0, BRDY);
        v(1,0,0,0,0,0,0,0,0,0,1, BRDY|LBV);
        v(1,0,0,0,0,0,0,0,0,0,0, '0);
        v(1,1,0,0,0,0,0,0,0,0,0, '0);
        v(1,1,0,0,0,0,0,0,0,0,0, MARV|RRDY);
        v(1,1,0,0,0,1,0,0,0,0,0, MARV|RRDY|IARR);
        v(1,0,0,0,0,0,0,0,0,0,0, RRDY);
        v(1,0,0,0,0,0,1,0,0,0,0, RRDY|IRV);
        v(1,0,0,0,0,0,1,1,0,0,0, RRDY|IRV);
        v(1,1,1,0,0,0,0,0,0,0,0, '0);
        v(1,1,1,0,0,1,0,0,0,0,0, MARV|ARID|RRDY|LARR);
        v(1,1,0,0,0,0,1,1,0,0,0, ARID|RRDY|LRV);
        v(1,1,1,0,0,0,0,0,0,0,0, '0);
        v(1,1,1,0,0,0,0,0,0,0,0, RR ? (MARV|RRDY) : (MARV|ARID|RRDY));
        v(1,1,1,0,0,0,1,1,0,0,0, RR ? (MARV|RRDY|IRV) : (MARV|ARID|RRDY|LRV));
        v(1,1,1,0,0,0,0,0,0,0,0, '0);
        v(1,1,1,0,0,1,0,0,0,0,0, MARV|ARID|RRDY|LARR);
        v(1,1,0,0,0,0,1,1,0,0,0, ARID|RRDY|LRV);

        clr(); rst_n = 0;
        @(negedge clk); @(negedge clk);

        foreach (tbl[i]) begin
            logic [12:0] act;
            @(negedge clk);
            rst_n = tbl[i].rst_n; ifu_arvalid = tbl[i].ifu; lsu_arvalid = tbl[i].lar;
            lsu_awvalid = tbl[i].law; lsu_wvalid = tbl[i].lw; m_arready = tbl[i].arr;
            m_rvalid = tbl[i].rv; m_rlast = tbl[i].rl; m_awready = tbl[i].awr;
            m_wready = tbl[i].wr; m_bvalid = tbl[i].bv;
            #1;
            act = {m_arvalid, m_arid[0], m_rready, m_awvalid, m_wvalid, m_bready,
                   ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready,
                   lsu_wready, lsu_bvalid};
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        // IFU read with a three-cycle slave response.
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
        @(negedge clk); #1;
        chk("ifu_grant_latency", m_arvalid, 1);
        chk("ifu_araddr", m_araddr, 32'h8000_0000);
        chk("ifu_arid", m_arid, 0);
        chk("ifu_arsize", m_arsize, 3'b010);
        chk("ifu_arlen", m_arlen, 0);
        chk("ifu_arburst", m_arburst, 2'b01);
        m_arready = 1; #1;
        chk("ifu_arready", ifu_arready, 1);
        @(negedge clk); ifu_arvalid = 0; m_arready = 0;
        @(negedge clk); @(negedge clk);
        m_rvalid = 1; m_rdata = 32'h0000_0413; m_rresp = 2'b00; m_rlast = 1; #1;
        chk("ifu_rvalid", ifu_rvalid, 1);
        chk("ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("ifu_rresp", ifu_rresp, 2'b00);
        chk("ifu_rd_lsu_rvalid", lsu_rvalid, 0);
        @(negedge clk); #1;
        chk("ifu_done_rvalid", ifu_rvalid, 0);
        chk("ifu_done_rready", m_rready, 0);

        // LSU write, W accepted before AW.
        do_reset();
        lsu_awvalid = 1; lsu_awaddr = 32'h0f00_0004; lsu_wvalid = 1;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1100;
        @(negedge clk); #1;
        chk("wr_awvalid", m_awvalid, 1);
        chk("wr_awaddr", m_awaddr, 32'h0f00_0004);
        chk("wr_awid", m_awid, 1);
        chk("wr_awlen", m_awlen, 0);
        chk("wr_awburst", m_awburst, 2'b01);
        chk("wr_wdata", m_wdata, 32'h1234_5678);
        chk("wr_wstrb", m_wstrb, 4'b1100);
        chk("wr_wlast", m_wlast, 1);
        m_wready = 1; #1;
        chk("wr_wready", lsu_wready, 1);
        chk("wr_awready_early", lsu_awready, 0);
        @(negedge clk); lsu_wvalid = 0; m_wready = 0; m_awready = 1; #1;
        chk("wr_awready", lsu_awready, 1);
        chk("wr_wvalid_after", m_wvalid, 0);
        @(negedge clk); lsu_awvalid = 0; m_awready = 0; m_bvalid = 1; m_bresp = 2'b00; #1;
        chk("wr_bvalid", lsu_bvalid, 1);
        chk("wr_bresp", lsu_bresp, 2'b00);
        @(negedge clk); #1;
        chk("wr_done_bvalid", lsu_bvalid, 0);
        chk("wr_done_bready", m_bready, 0);

        // LSU read returning SLVERR.
        do_reset();
        lsu_arvalid = 1; lsu_araddr = 32'h0000_1000; lsu_arsize = 3'b001;
        @(negedge clk); #1;
        chk("lrd_arid", m_arid, 1);
        chk("lrd_arsize", m_arsize, 3'b001);
        chk("lrd_araddr", m_araddr, 32'h0000_1000);
        m_arready = 1;
        @(negedge clk); lsu_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rlast = 1; m_rresp = 2'b10; m_rdata = 32'hdead_beef; #1;
        chk("lrd_rvalid", lsu_rvalid, 1);
        chk("lrd_rresp", lsu_rresp, 2'b10);
        chk("lrd_rdata", lsu_rdata, 32'hdead_beef);
        chk("lrd_ifu_rvalid", ifu_rvalid, 0);

        // Reset in LSU_WR after the AW handshake: the late B must not reach the LSU.
        do_reset();
        lsu_awvalid = 1; lsu_wvalid = 1;
        @(negedge clk); m_awready = 1; #1;
        chk("rst_wr_awready", lsu_awready, 1);
        @(negedge clk); lsu_awvalid = 0; m_awready = 0; rst_n = 0;
        @(negedge clk); rst_n = 1; m_bvalid = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rst_wr_bvalid%0d", k), lsu_bvalid, 0);
            chk($sformatf("rst_wr_wvalid%0d", k), m_wvalid, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
